// File: rtl/rv32i_load_store_unit.sv
// RV32I memory-access stage: one outstanding req/ack data-memory transaction with
// byte-lane steering, load extension, misalignment/illegal-code faults and a bus timeout.
module rv32i_load_store_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 32'd1);

    state_t      state_r;
    state_t      state_next_s;
    logic [7:0]  cnt_r;
    logic        is_store_r;
    logic [2:0]  funct3_r;
    logic [1:0]  lane_r;
    logic        accept_s;
    logic        fault_s;
    logic        ack_s;
    logic        timeout_s;
    logic [3:0]  wstrb_s;
    logic [31:0] wdata_s;

    function automatic logic access_fault(input logic st, input logic [2:0] f3, input logic [1:0] a);
        logic illegal;
        if (st) begin
            illegal = (f3 > 3'd2);
        end else begin
            illegal = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        end
        return illegal || ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lane,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = word;
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Store lane steering from the request being accepted; loads drive no strobes.
    always_comb begin
        wstrb_s = 4'b0000;
        wdata_s = 32'd0;
        if (is_store) begin
            case (funct3)
                3'b000: begin
                    wstrb_s = 4'b0001 << addr[1:0];
                    wdata_s = {4{wdata[7:0]}};
                end
                3'b001: begin
                    wstrb_s = addr[1] ? 4'b1100 : 4'b0011;
                    wdata_s = {2{wdata[15:0]}};
                end
                3'b010: begin
                    wstrb_s = 4'b1111;
                    wdata_s = wdata;
                end
                default: begin
                    wstrb_s = 4'b0000;
                    wdata_s = 32'd0;
                end
            endcase
        end else begin
            wstrb_s = 4'b0000;
            wdata_s = 32'd0;
        end
    end

    // Next-state logic; an ack in the final timeout cycle takes priority over the abort.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        ack_s        = 1'b0;
        timeout_s    = 1'b0;
        fault_s      = access_fault(is_store, funct3, addr[1:0]);
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = fault_s ? RESP : ACCESS;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    ack_s        = 1'b1;
                    state_next_s = RESP;
                end else if (cnt_r == CNT_LAST) begin
                    timeout_s    = 1'b1;
                    state_next_s = RESP;
                end else begin
                    state_next_s = ACCESS;
                end
            end
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register and the ready flag that mirrors the upcoming IDLE state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            req_ready <= 1'b1;
        end else begin
            state_r   <= state_next_s;
            req_ready <= (state_next_s == IDLE);
        end
    end

    // Wait-cycle counter, restarted at every accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 8'd0;
        end else if (accept_s) begin
            cnt_r <= 8'd0;
        end else if ((state_r == ACCESS) && !mem_ack) begin
            cnt_r <= cnt_r + 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Request capture and memory-side outputs, held stable for the whole access.
    always_ff @(posedge clk) begin
        if (rst) begin
            is_store_r <= 1'b0;
            funct3_r   <= 3'd0;
            lane_r     <= 2'd0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wstrb  <= 4'd0;
            mem_wdata  <= 32'd0;
        end else if (accept_s && !fault_s) begin
            is_store_r <= is_store;
            funct3_r   <= funct3;
            lane_r     <= addr[1:0];
            mem_req    <= 1'b1;
            mem_we     <= is_store;
            mem_addr   <= {addr[31:2], 2'b00};
            mem_wstrb  <= wstrb_s;
            mem_wdata  <= wdata_s;
        end else if (ack_s || timeout_s) begin
            mem_req <= 1'b0;
        end else begin
            mem_req <= mem_req;
        end
    end

    // Response fields are live only during the single RESP cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            rdata      <= 32'd0;
        end else begin
            resp_valid <= 1'b0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            rdata      <= 32'd0;
            if (accept_s && fault_s) begin
                resp_valid <= 1'b1;
                misaligned <= 1'b1;
            end else if (ack_s) begin
                resp_valid <= 1'b1;
                rdata      <= is_store_r ? 32'd0 : load_extract(funct3_r, lane_r, mem_rdata);
            end else if (timeout_s) begin
                resp_valid <= 1'b1;
                bus_err    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rv32i_load_store_unit.sv
// Directed and randomized bench for rv32i_load_store_unit against an arithmetic
// reference model of the access rules.
module tb_rv32i_load_store_unit;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        misaligned;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int vectors = 0;
    int errors  = 0;

    rv32i_load_store_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .is_store(is_store), .funct3(funct3), .addr(addr), .wdata(wdata),
        .resp_valid(resp_valid), .rdata(rdata), .misaligned(misaligned), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes, legality and alignment by arithmetic.
    function automatic int nbytes(input logic [2:0] f3);
        return 1 << (f3 % 4);
    endfunction

    function automatic logic exp_fault(input logic st, input logic [2:0] f3, input logic [31:0] a);
        logic legal;
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        return !legal || ((a % nbytes(f3)) != 0);
    endfunction

    function automatic logic [3:0] exp_wstrb(input logic st, input logic [2:0] f3, input logic [31:0] a);
        int m;
        m = ((1 << nbytes(f3)) - 1) << (a % 4);
        return st ? m[3:0] : 4'd0;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic st, input logic [2:0] f3, input logic [31:0] wd);
        if (!st) return 32'd0;
        if (nbytes(f3) == 1) return wd[7:0] * 32'h0101_0101;
        if (nbytes(f3) == 2) return wd[15:0] * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] word);
        longint v;
        int nb;
        if (st) return 32'd0;
        nb = nbytes(f3);
        v  = word;
        v  = (v >> (8 * (a % 4))) % (64'd1 << (8 * nb));
        if ((f3 < 3'd4) && (nb < 4) && (v >= (64'd1 << (8 * nb - 1))))
            v = v - (64'd1 << (8 * nb));
        return v[31:0];
    endfunction

    // One complete transaction from IDLE; delay = wait cycles before ack, <0 means never ack.
    task automatic txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int delay, input logic [31:0] word);
        logic        flt;
        logic        ack_seen;
        logic [31:0] er;
        int          i;
        flt = exp_fault(st, f3, a);
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
        @(negedge clk);
        req_valid = 1'b0; addr = $urandom; wdata = $urandom;
        chk("req_ready_busy", req_ready, 0);
        if (flt) begin
            chk("fault_resp_valid", resp_valid, 1);
            chk("fault_misaligned", misaligned, 1);
            chk("fault_bus_err", bus_err, 0);
            chk("fault_rdata", rdata, 0);
            chk("fault_mem_req", mem_req, 0);
        end else begin
            ack_seen = 1'b0;
            i = 0;
            while (!ack_seen && i < TO) begin
                chk("acc_mem_req", mem_req, 1);
                chk("acc_mem_addr", mem_addr, {a[31:2], 2'b00});
                chk("acc_mem_we", mem_we, st);
                chk("acc_mem_wstrb", mem_wstrb, exp_wstrb(st, f3, a));
                chk("acc_mem_wdata", mem_wdata, exp_wdata(st, f3, wd));
                chk("acc_resp_valid", resp_valid, 0);
                if (i == delay) begin
                    mem_ack = 1'b1; mem_rdata = word; ack_seen = 1'b1;
                end else begin
                    mem_ack = 1'b0; mem_rdata = $urandom;
                end
                i++;
                @(negedge clk);
            end
            mem_ack = 1'b0;
            er = ack_seen ? exp_rdata(st, f3, a, word) : 32'd0;
            chk("resp_valid", resp_valid, 1);
            chk("resp_rdata", rdata, er);
            chk("resp_bus_err", bus_err, !ack_seen);
            chk("resp_misaligned", misaligned, 0);
            chk("resp_mem_req", mem_req, 0);
            chk("resp_req_ready", req_ready, 0);
        end
        @(negedge clk);
        chk("post_resp_valid", resp_valid, 0);
        chk("post_req_ready", req_ready, 1);
        chk("post_flags", {bus_err, misaligned}, 0);
        chk("post_rdata", rdata, 0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = 32'd0;
        wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wstrb", mem_wstrb, 0);
        chk("rst_rdata", rdata, 0);
        rst = 1'b0;

        // Byte loads with sign and zero extension.
        txn(1'b0, 3'b000, 32'h1003, 32'd0, 1, 32'h80FF_1234);
        txn(1'b0, 3'b100, 32'h1003, 32'd0, 1, 32'h80FF_1234);
        // Halfword store and load on the upper lane.
        txn(1'b1, 3'b001, 32'h2002, 32'hDEAD_BEEF, 0, 32'd0);
        txn(1'b0, 3'b101, 32'h2002, 32'd0, 0, 32'hBEEF_0000);
        // Misalignment and illegal store code.
        txn(1'b0, 3'b010, 32'h3001, 32'd0, 0, 32'd0);
        txn(1'b1, 3'b001, 32'h3001, 32'h1111_2222, 0, 32'd0);
        txn(1'b1, 3'b011, 32'h3000, 32'h1111_2222, 0, 32'd0);
        // Wait states, then a full timeout.
        txn(1'b0, 3'b010, 32'h3100, 32'd0, 5, 32'hCAFE_F00D);
        txn(1'b0, 3'b010, 32'h3200, 32'd0, -1, 32'd0);

        // A late ack while idle must be ignored.
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("late_ack_resp", resp_valid, 0);
        chk("late_ack_mem_req", mem_req, 0);
        mem_ack = 1'b0;

        // Reset in the third ACCESS cycle discards the transaction.
        @(negedge clk);
        req_valid = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h100;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_mid_req_on", mem_req, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_mem_req", mem_req, 0);
        chk("rst_mid_req_ready", req_ready, 1);
        chk("rst_mid_resp", resp_valid, 0);
        rst = 1'b0; mem_ack = 1'b1;
        @(negedge clk);
        chk("rst_mid_ack_ignored", resp_valid, 0);
        mem_ack = 1'b0;
        txn(1'b1, 3'b010, 32'h40, 32'h1234_5678, 0, 32'd0);

        // Back-to-back: req_valid held high across two requests.
        @(negedge clk);
        req_valid = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h500;
        @(negedge clk);
        chk("b2b_a_access", mem_req, 1);
        chk("b2b_ready_access", req_ready, 0);
        is_store = 1'b1; funct3 = 3'b010; addr = 32'h80; wdata = 32'hA5A5_0001;
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_CAFE;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("b2b_a_resp", resp_valid, 1);
        chk("b2b_a_rdata", rdata, 32'h0BAD_CAFE);
        chk("b2b_ready_resp", req_ready, 0);
        @(negedge clk);
        chk("b2b_idle_ready", req_ready, 1);
        chk("b2b_idle_no_req", mem_req, 0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_b_req", mem_req, 1);
        chk("b2b_b_addr", mem_addr, 32'h80);
        chk("b2b_b_we", mem_we, 1);
        chk("b2b_b_wdata", mem_wdata, 32'hA5A5_0001);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("b2b_b_resp", resp_valid, 1);
        chk("b2b_b_rdata", rdata, 0);

        // Randomized mix of legal, misaligned and illegal accesses, waits and timeouts.
        for (int n = 0; n < 40; n++) begin
            txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                int'($urandom_range(0, 17)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
